// File: rtl/s_axis_cc_arbiter_pkg.sv
// Shared types and constants for the CC completion-stream arbiter.
// The tuser width matches the downstream CC adapter.
package s_axis_cc_arbiter_pkg;

  localparam int unsigned CC_USER_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream register slice: one cycle of latency,
// full throughput while the consumer is ready, holds when stalled.
module axis_reg_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         valid_q;
  logic [W-1:0] data_q;
  logic         load_en;

  assign load_en    = !valid_q || out_ready_i;
  assign in_ready_o = load_en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_en) begin
      valid_q <= in_valid_i;
      if (in_valid_i) data_q <= in_data_i;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/s_axis_cc_arbiter.sv
// Packet-granular round-robin merge of two CC completion streams
// into one registered AXI-Stream output.
module s_axis_cc_arbiter
  import s_axis_cc_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s0_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_axis_cc_tkeep,
  input  logic                  s0_axis_cc_tlast,
  input  logic [CC_USER_W-1:0]  s0_axis_cc_tuser,
  input  logic                  s0_axis_cc_tvalid,
  output logic                  s0_axis_cc_tready,
  input  logic [DATA_WIDTH-1:0] s1_axis_cc_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_axis_cc_tkeep,
  input  logic                  s1_axis_cc_tlast,
  input  logic [CC_USER_W-1:0]  s1_axis_cc_tuser,
  input  logic                  s1_axis_cc_tvalid,
  output logic                  s1_axis_cc_tready,
  output logic [DATA_WIDTH-1:0] m_axis_cc_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_cc_tkeep,
  output logic                  m_axis_cc_tlast,
  output logic [CC_USER_W-1:0]  m_axis_cc_tuser,
  output logic                  m_axis_cc_tvalid,
  input  logic                  m_axis_cc_tready,
  output logic                  busy,
  output logic [1:0]            grant
);

  localparam int unsigned PW = DATA_WIDTH + KEEP_WIDTH + CC_USER_W + 1;

  arb_state_e    state_q;
  logic          rr_q;
  logic [1:0]    grant_q;
  logic          rdy_q;

  logic          sel;
  logic          own_v;
  logic          own_last;
  logic          en;
  logic          acc;
  logic          load_en;
  logic [PW-1:0] in_data;
  logic [PW-1:0] out_data;

  // In BUSY the owner is locked; in IDLE rr only breaks ties.
  always_comb begin
    sel = 1'b0;
    if (state_q == ST_BUSY)
      sel = grant_q[1];
    else if (s0_axis_cc_tvalid && s1_axis_cc_tvalid)
      sel = rr_q;
    else
      sel = s1_axis_cc_tvalid;
  end

  assign own_v    = sel ? s1_axis_cc_tvalid : s0_axis_cc_tvalid;
  assign own_last = sel ? s1_axis_cc_tlast  : s0_axis_cc_tlast;

  assign en = rdy_q && load_en &&
              ((state_q == ST_BUSY) ||
               s0_axis_cc_tvalid || s1_axis_cc_tvalid);

  assign s0_axis_cc_tready = en && !sel;
  assign s1_axis_cc_tready = en && sel;
  assign acc               = en && own_v;

  assign in_data = sel
    ? {s1_axis_cc_tdata, s1_axis_cc_tkeep,
       s1_axis_cc_tuser, s1_axis_cc_tlast}
    : {s0_axis_cc_tdata, s0_axis_cc_tkeep,
       s0_axis_cc_tuser, s0_axis_cc_tlast};

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      grant_q <= 2'b00;
      rdy_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (acc) begin
        if (own_last) begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
          rr_q    <= !sel;
        end else if (state_q == ST_IDLE) begin
          state_q <= ST_BUSY;
          grant_q <= sel ? 2'b10 : 2'b01;
        end
      end
    end
  end

  axis_reg_slice #(.W(PW)) u_out (
    .clk_i       (user_clk),
    .rst_i       (user_reset),
    .in_valid_i  (acc),
    .in_data_i   (in_data),
    .in_ready_o  (load_en),
    .out_valid_o (m_axis_cc_tvalid),
    .out_data_o  (out_data),
    .out_ready_i (m_axis_cc_tready)
  );

  assign {m_axis_cc_tdata, m_axis_cc_tkeep,
          m_axis_cc_tuser, m_axis_cc_tlast} = out_data;

  assign busy  = (state_q == ST_BUSY);
  assign grant = grant_q;

endmodule

// File: tb/tb_s_axis_cc_arbiter.sv
// Scoreboard bench for s_axis_cc_arbiter: per-port source queues,
// expected output order pushed up front and checked at the output.
module tb_s_axis_cc_arbiter;

  localparam int DW = 64;
  localparam int KW = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [3:0]    user;
    int            gap;
  } beat_t;

  logic          clk = 1'b0;
  logic          user_reset;
  logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
  logic [KW-1:0] s0_tkeep, s1_tkeep, m_tkeep;
  logic          s0_tlast, s1_tlast, m_tlast;
  logic [3:0]    s0_tuser, s1_tuser, m_tuser;
  logic          s0_tvalid, s1_tvalid, m_tvalid;
  logic          s0_tready, s1_tready, m_tready;
  logic          busy;
  logic [1:0]    grant;

  beat_t src0_q[$];
  beat_t src1_q[$];
  beat_t exp_q[$];

  int  gap0 = 0, gap1 = 0;
  bit  acc0 = 0, acc1 = 0;
  bit  hold_q = 0;
  logic [127:0] held;
  int  run_len = 0, max_run = 0;
  int  n_cmp = 0, n_bad = 0;

  s_axis_cc_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .user_clk          (clk),
    .user_reset        (user_reset),
    .s0_axis_cc_tdata  (s0_tdata),
    .s0_axis_cc_tkeep  (s0_tkeep),
    .s0_axis_cc_tlast  (s0_tlast),
    .s0_axis_cc_tuser  (s0_tuser),
    .s0_axis_cc_tvalid (s0_tvalid),
    .s0_axis_cc_tready (s0_tready),
    .s1_axis_cc_tdata  (s1_tdata),
    .s1_axis_cc_tkeep  (s1_tkeep),
    .s1_axis_cc_tlast  (s1_tlast),
    .s1_axis_cc_tuser  (s1_tuser),
    .s1_axis_cc_tvalid (s1_tvalid),
    .s1_axis_cc_tready (s1_tready),
    .m_axis_cc_tdata   (m_tdata),
    .m_axis_cc_tkeep   (m_tkeep),
    .m_axis_cc_tlast   (m_tlast),
    .m_axis_cc_tuser   (m_tuser),
    .m_axis_cc_tvalid  (m_tvalid),
    .m_axis_cc_tready  (m_tready),
    .busy              (busy),
    .grant             (grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pk(input beat_t b);
    return {51'd0, b.data, b.keep, b.user, b.last};
  endfunction

  task automatic add_pkt(input int port, input int pkt, input int n,
                         input logic [3:0] ulast, input int gapidx);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = {16'(port), 16'(pkt), 16'(i), 16'hA5C3};
      b.last = (i == n - 1);
      b.keep = b.last ? 8'h0F : 8'hFF;
      b.user = b.last ? ulast : 4'h0;
      b.gap  = (i == gapidx) ? 2 : 0;
      if (port == 0) src0_q.push_back(b);
      else           src1_q.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive();
    s0_tvalid = (src0_q.size() > 0) && (gap0 == 0);
    s1_tvalid = (src1_q.size() > 0) && (gap1 == 0);
    if (src0_q.size() > 0)
      {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} =
        {src0_q[0].data, src0_q[0].keep, src0_q[0].user, src0_q[0].last};
    else
      {s0_tdata, s0_tkeep, s0_tuser, s0_tlast} = '0;
    if (src1_q.size() > 0)
      {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} =
        {src1_q[0].data, src1_q[0].keep, src1_q[0].user, src1_q[0].last};
    else
      {s1_tdata, s1_tkeep, s1_tuser, s1_tlast} = '0;
  endtask

  always @(posedge clk) begin
    #1;
    if (acc0) begin
      void'(src0_q.pop_front());
      gap0 = (src0_q.size() > 0) ? src0_q[0].gap : 0;
    end else if (gap0 > 0) gap0--;
    if (acc1) begin
      void'(src1_q.pop_front());
      gap1 = (src1_q.size() > 0) ? src1_q[0].gap : 0;
    end else if (gap1 > 0) gap1--;
    drive();
  end

  always @(negedge clk) begin
    logic [127:0] cur;
    beat_t e;
    cur  = {51'd0, m_tdata, m_tkeep, m_tuser, m_tlast};
    acc0 = s0_tvalid && s0_tready;
    acc1 = s1_tvalid && s1_tready;
    if (!user_reset) begin
      if (s0_tready || s1_tready)
        chk("tready_1hot", 128'(s0_tready & s1_tready), 128'(0));
      if (hold_q) begin
        chk("hold_valid", 128'(m_tvalid), 128'(1));
        chk("hold_payload", cur, held);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("extra_beat", 128'(1), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk("beat", cur, pk(e));
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else run_len = 0;
      hold_q = m_tvalid && !m_tready;
      held   = cur;
    end else begin
      hold_q  = 0;
      run_len = 0;
    end
  end

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() > 0 || src0_q.size() > 0 || src1_q.size() > 0)
           && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (t >= 300) chk("drain_timeout", 128'(1), 128'(0));
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    user_reset = 1'b1;
    m_tready   = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_tready", 128'({s0_tready, s1_tready}), 128'(0));
    chk("rst_tdata", 128'(m_tdata), 128'(0));

    // first cycle after release never accepts
    add_pkt(1, 1, 1, 4'h0, -1);
    drive();
    user_reset = 1'b0;
    @(negedge clk);
    chk("rdy_first_cyc", 128'(s1_tready), 128'(0));
    @(negedge clk);
    chk("rdy_second_cyc", 128'(s1_tready), 128'(1));
    wait_drain();

    // both ports, 3-beat packets, rr favours port 0
    max_run = 0;
    add_pkt(0, 2, 3, 4'h0, -1);
    add_pkt(1, 3, 3, 4'h0, -1);
    drive();
    @(negedge clk);
    chk("both_s0rdy", 128'(s0_tready), 128'(1));
    chk("both_s1rdy", 128'(s1_tready), 128'(0));
    @(posedge clk); #2;
    chk("both_grant0", 128'(grant), 128'(2'b01));
    chk("both_busy", 128'(busy), 128'(1));
    repeat (3) @(posedge clk);
    #2;
    chk("both_grant1", 128'(grant), 128'(2'b10));
    wait_drain();
    chk("both_no_gap", 128'(max_run), 128'(6));

    // port 1 single-beat packets back to back
    max_run = 0;
    for (int i = 0; i < 4; i++) add_pkt(1, 10 + i, 1, 4'h0, -1);
    drive();
    repeat (4) begin
      @(negedge clk);
      chk("single_busy", 128'(busy), 128'(0));
    end
    wait_drain();
    chk("single_no_gap", 128'(max_run), 128'(4));

    // output stall mid-packet; rr back at 0 so port 0 first
    add_pkt(0, 20, 3, 4'h0, -1);
    add_pkt(1, 21, 2, 4'h0, -1);
    drive();
    repeat (2) @(posedge clk);
    #2;
    m_tready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("stall_s0rdy", 128'(s0_tready), 128'(0));
      chk("stall_s1rdy", 128'(s1_tready), 128'(0));
      @(posedge clk); #2;
    end
    m_tready = 1'b1;
    wait_drain();

    // owner gap keeps the grant
    add_pkt(0, 30, 3, 4'h0, 1);
    add_pkt(1, 31, 1, 4'h0, -1);
    drive();
    @(posedge clk); #2;
    repeat (2) begin
      @(negedge clk);
      chk("gap_grant", 128'(grant), 128'(2'b01));
      chk("gap_s1rdy", 128'(s1_tready), 128'(0));
      chk("gap_s0valid", 128'(s0_tvalid), 128'(0));
      @(posedge clk); #2;
    end
    wait_drain();

    // tuser passthrough with one-cycle latency
    add_pkt(0, 41, 1, 4'b1001, -1);
    drive();
    @(negedge clk);
    chk("lat_s0rdy", 128'(s0_tready), 128'(1));
    @(negedge clk);
    chk("lat_tvalid", 128'(m_tvalid), 128'(1));
    chk("lat_tuser", 128'(m_tuser), 128'(4'b1001));
    wait_drain();
    add_pkt(0, 40, 2, 4'b1001, -1);
    drive();
    wait_drain();

    // rr now favours port 1
    add_pkt(1, 50, 1, 4'h0, -1);
    add_pkt(0, 51, 1, 4'h0, -1);
    drive();
    wait_drain();

    // reset on beat 2 of a 4-beat packet
    add_pkt(0, 60, 4, 4'h0, -1);
    drive();
    repeat (2) @(posedge clk);
    #2;
    user_reset = 1'b1;
    #1;
    chk("rmid_tvalid", 128'(m_tvalid), 128'(0));
    chk("rmid_busy", 128'(busy), 128'(0));
    chk("rmid_grant", 128'(grant), 128'(0));
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    gap0 = 0;
    gap1 = 0;
    drive();
    repeat (2) @(posedge clk);
    #2;
    user_reset = 1'b0;
    add_pkt(1, 70, 2, 4'h0, -1);
    drive();
    repeat (2) @(posedge clk);
    #2;
    chk("rel_grant", 128'(grant), 128'(2'b10));
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/s_axis_cc_arbiter.md
S_AXIS_CC_ARBITER -- requirements
Module: s_axis_cc_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 512: tdata width of all ports.
REQ-002 Parameter KEEP_WIDTH, default DATA_WIDTH/8: byte-enable width of all ports.
REQ-003 user_clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-004 user_reset  input  1  asynchronous, active-high reset.
REQ-005 s0_axis_cc_tdata/tkeep/tlast/tuser/tvalid  input  DATA_WIDTH/KEEP_WIDTH/1/4/1  completion stream from requester 0.
REQ-006 s0_axis_cc_tready  output  1  ready to requester 0.
REQ-007 s1_axis_cc_tdata/tkeep/tlast/tuser/tvalid  input  DATA_WIDTH/KEEP_WIDTH/1/4/1  completion stream from requester 1.
REQ-008 s1_axis_cc_tready  output  1  ready to requester 1.
REQ-009 m_axis_cc_tdata/tkeep/tlast/tuser/tvalid  output  DATA_WIDTH/KEEP_WIDTH/1/4/1  merged stream to the CC adapter.
REQ-010 m_axis_cc_tready  input  1  ready from the CC adapter.
REQ-011 busy  output  1  high while a packet is locked (state BUSY).
REQ-012 grant  output  2  one-hot owner of the current packet; 2'b00 when IDLE.

Function
REQ-013 Arbitration SHALL be packet-granular; the owner SHALL not change until its tlast beat is accepted.
REQ-014 FSM SHALL have states IDLE and BUSY.
REQ-015 IDLE: if any sN_tvalid, the winner SHALL be chosen combinationally by round-robin pointer rr (rr=0 favours port 0, rr=1 favours port 1); its first beat SHALL be accepted that cycle if the output stage can load.
REQ-016 IDLE -> BUSY on acceptance of a non-tlast beat; IDLE stays IDLE on acceptance of a single-beat (tlast) packet.
REQ-017 BUSY -> IDLE on acceptance of the owner's tlast beat.
REQ-018 On every accepted tlast beat rr SHALL be set to the opposite of the port that sent it.
REQ-019 Only the owner's tready SHALL ever be high; a non-owner's tready SHALL be 0.
REQ-020 Output stage SHALL be a single register: load_en = !m_tvalid || m_tready; owner tready = load_en.
REQ-021 Latency from accepted input beat to m_axis_cc_tvalid SHALL be exactly 1 cycle; full throughput (1 beat/cycle) SHALL hold while m_tready=1.
REQ-022 m_axis_cc_tvalid SHALL drop to 0 when the register is unloaded and no beat is loaded that cycle.
REQ-023 tdata, tkeep, tlast, tuser SHALL pass unmodified; tuser[3] (discontinue) and tuser[0] (ECRC) are carried, not interpreted.
REQ-024 While m_tvalid=1 and m_tready=0 all m_axis_cc_* outputs SHALL hold stable.
REQ-025 Owner deasserting tvalid mid-packet SHALL stall the output (gap) without releasing the grant.
REQ-026 Both valid in IDLE: rr decides; only one valid: that port wins regardless of rr.
REQ-027 busy/grant SHALL be registered state outputs, grant valid in BUSY and 2'b00 in IDLE.

Reset
REQ-028 On user_reset: state=IDLE, rr=0, m_axis_cc_tvalid=0, busy=0, grant=0, s0/s1 tready=0; m_tdata/tkeep/tlast/tuser SHALL reset to 0.
REQ-029 Reset mid-packet SHALL abandon the packet in flight; after deassertion arbitration restarts fresh; upstream is responsible for resynchronising.
REQ-030 tready SHALL be 0 during reset and the first cycle after deassertion.

Structure
REQ-031 No shared package is required; widths are parameters; the 4-bit tuser width SHALL be a localparam matching the adapter.
REQ-032 The output register SHALL be a sub-module axis_reg_slice (parameterised payload width DATA_WIDTH+KEEP_WIDTH+4+1).
REQ-033 Total RTL SHALL target 150-300 lines.

Verification
REQ-034 Both ports present 3-beat packets at t0, rr=0, m_tready=1 -> port0 beats out t1..t3, port1 beats t4..t6, no gap, grant 01 then 10.
REQ-035 Port1 only, 1-beat packet repeated, m_tready=1 -> one beat per cycle out, state stays IDLE, rr=0 after each.
REQ-036 Port0 mid-packet, m_tready low 4 cycles -> m outputs frozen, s0_tready=0 those cycles, s1_tready=0 throughout.
REQ-037 Port0 drops tvalid 2 cycles mid-packet while port1 valid -> grant stays 01, port1 waits until port0 tlast accepted.
REQ-038 user_reset asserted on beat 2 of a 4-beat packet -> m_tvalid=0, busy=0, grant=00 immediately; next packet from port1 wins after release.
REQ-039 tuser=4'b1001 on port0 tlast beat -> appears unchanged on m_axis_cc_tuser one cycle later.
